// File: rtl/crossbar_2x2_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_2x2_scheduler_pkg
// Description : Shared encodings for the 2x2 crossbar packet scheduler.
//               Provides the FSM state type, the crossbar control and
//               destination encodings, and a helper that maps
//               (source input, destination) to a crossbar setting.
// Revision    : 1.0 - initial release
// ============================================================================
package crossbar_2x2_scheduler_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic CTRL_STRAIGHT = 1'b1;
    localparam logic CTRL_CROSS    = 1'b0;
    localparam logic DEST_OUT1     = 1'b0;
    localparam logic DEST_OUT2     = 1'b1;
    localparam logic SRC_IN1       = 1'b0;
    localparam logic SRC_IN2       = 1'b1;

    // Straight when input index and output index match (in1->out1, in2->out2).
    function automatic logic route_ctrl(input logic src, input logic dest);
        logic from_in1;
        logic to_out1;
        from_in1 = (src == SRC_IN1);
        to_out1  = (dest == DEST_OUT1);
        return (from_in1 == to_out1) ? CTRL_STRAIGHT : CTRL_CROSS;
    endfunction

endpackage : crossbar_2x2_scheduler_pkg
`default_nettype wire

// File: rtl/crossbar_2x2_scheduler_xbar.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_2x2_scheduler_xbar
// Description : Combinational 2x2 crossbar lane.
//               ctrl_i = 1 : in1 -> out1, in2 -> out2 (straight)
//               ctrl_i = 0 : in1 -> out2, in2 -> out1 (cross)
// Ports       : ctrl_i        crossbar setting
//               in1_i, in2_i  lane inputs  [W-1:0]
//               out1_o, out2_o lane outputs [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_2x2_scheduler_xbar
    import crossbar_2x2_scheduler_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         ctrl_i,
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] in2_i,
    output logic [W-1:0] out1_o,
    output logic [W-1:0] out2_o
);

    assign out1_o = (ctrl_i == CTRL_STRAIGHT) ? in1_i : in2_i;
    assign out2_o = (ctrl_i == CTRL_STRAIGHT) ? in2_i : in1_i;

endmodule : crossbar_2x2_scheduler_xbar
`default_nettype wire

// File: rtl/crossbar_2x2_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_2x2_scheduler
// Description : Packet scheduler around a 2x2 crossbar. Arbitrates two
//               valid/ready input streams by destination, locks the crossbar
//               setting for whole packets, resolves output conflicts
//               round-robin and counts them (saturating).
// Ports       : clk, rst                 clock / sync active-high reset
//               inN_valid/dest/last/data_i, inN_ready_o   input streams
//               outN_valid/last/data_o, outN_ready_i      output streams
//               xbar_ctrl_o  1 = straight, 0 = cross
//               busy_o       high while a configuration is locked
//               conflict_cnt_o  saturating count of resolved conflicts
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_2x2_scheduler
    import crossbar_2x2_scheduler_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    // input 1
    input  logic              in1_valid_i,
    input  logic              in1_dest_i,
    input  logic              in1_last_i,
    input  logic [DATA_W-1:0] in1_data_i,
    output logic              in1_ready_o,
    // input 2
    input  logic              in2_valid_i,
    input  logic              in2_dest_i,
    input  logic              in2_last_i,
    input  logic [DATA_W-1:0] in2_data_i,
    output logic              in2_ready_o,
    // output 1
    output logic              out1_valid_o,
    output logic              out1_last_o,
    output logic [DATA_W-1:0] out1_data_o,
    input  logic              out1_ready_i,
    // output 2
    output logic              out2_valid_o,
    output logic              out2_last_o,
    output logic [DATA_W-1:0] out2_data_o,
    input  logic              out2_ready_i,
    // status
    output logic              xbar_ctrl_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [1:0]       act_q, act_d;     // bit SRC_IN1 = in1 granted, bit SRC_IN2 = in2 granted
    logic             ctrl_q, ctrl_d;
    logic             rr_q, rr_d;       // input that wins the next conflict
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             straight;
    logic             in1_done;
    logic             in2_done;
    logic             out1_act;
    logic             out2_act;
    logic [1:0]       ctl1_routed;      // {valid, last} arriving at output 1
    logic [1:0]       ctl2_routed;      // {valid, last} arriving at output 2

    assign busy     = (state_q == ST_BUSY);
    assign straight = (ctrl_q == CTRL_STRAIGHT);

    // ------------------------------------------------------------------
    // Datapath: payload lanes and {valid,last} lanes share the setting.
    // ------------------------------------------------------------------
    crossbar_2x2_scheduler_xbar #(.W(DATA_W)) u_xbar_data (
        .ctrl_i (ctrl_q),
        .in1_i  (in1_data_i),
        .in2_i  (in2_data_i),
        .out1_o (out1_data_o),
        .out2_o (out2_data_o)
    );

    crossbar_2x2_scheduler_xbar #(.W(2)) u_xbar_ctl (
        .ctrl_i (ctrl_q),
        .in1_i  ({in1_valid_i, in1_last_i}),
        .in2_i  ({in2_valid_i, in2_last_i}),
        .out1_o (ctl1_routed),
        .out2_o (ctl2_routed)
    );

    // An output is in use only when the input feeding it holds a grant.
    assign out1_act = busy & (straight ? act_q[SRC_IN1] : act_q[SRC_IN2]);
    assign out2_act = busy & (straight ? act_q[SRC_IN2] : act_q[SRC_IN1]);

    assign out1_valid_o = out1_act & ctl1_routed[1];
    assign out1_last_o  = out1_act & ctl1_routed[0];
    assign out2_valid_o = out2_act & ctl2_routed[1];
    assign out2_last_o  = out2_act & ctl2_routed[0];

    // Each granted input sees only the ready of the output it drives,
    // so backpressure on one path never stalls the other.
    assign in1_ready_o = busy & act_q[SRC_IN1] & (straight ? out1_ready_i : out2_ready_i);
    assign in2_ready_o = busy & act_q[SRC_IN2] & (straight ? out2_ready_i : out1_ready_i);

    assign in1_done = in1_valid_i & in1_ready_o & in1_last_i;
    assign in2_done = in2_valid_i & in2_ready_o & in2_last_i;

    // ------------------------------------------------------------------
    // Scheduler next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        ctrl_d  = ctrl_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in1_valid_i && in2_valid_i) begin
                    state_d = ST_BUSY;
                    if (in1_dest_i != in2_dest_i) begin
                        // Disjoint destinations: both fit in one setting.
                        ctrl_d = route_ctrl(SRC_IN1, in1_dest_i);
                        act_d  = 2'b11;
                    end else begin
                        act_d          = 2'b00;
                        act_d[rr_q]    = 1'b1;
                        ctrl_d         = route_ctrl(rr_q, (rr_q == SRC_IN1) ? in1_dest_i : in2_dest_i);
                        rr_d           = ~rr_q;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end else if (in1_valid_i) begin
                    state_d = ST_BUSY;
                    ctrl_d  = route_ctrl(SRC_IN1, in1_dest_i);
                    act_d   = 2'b00;
                    act_d[SRC_IN1] = 1'b1;
                end else if (in2_valid_i) begin
                    state_d = ST_BUSY;
                    ctrl_d  = route_ctrl(SRC_IN2, in2_dest_i);
                    act_d   = 2'b00;
                    act_d[SRC_IN2] = 1'b1;
                end
            end
            ST_BUSY: begin
                act_d[SRC_IN1] = act_q[SRC_IN1] & ~in1_done;
                act_d[SRC_IN2] = act_q[SRC_IN2] & ~in2_done;
                if (act_d == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                act_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            act_q   <= 2'b00;
            ctrl_q  <= CTRL_STRAIGHT;
            rr_q    <= SRC_IN1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            ctrl_q  <= ctrl_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign xbar_ctrl_o    = ctrl_q;
    assign busy_o         = busy;
    assign conflict_cnt_o = cnt_q;

endmodule : crossbar_2x2_scheduler
`default_nettype wire

// File: tb/tb_crossbar_2x2_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossbar_2x2_scheduler
// Description : Directed self-checking bench for crossbar_2x2_scheduler.
//               Inputs change 1 time unit after the rising edge; outputs are
//               compared 1 time unit later, well away from the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_2x2_scheduler;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in1_valid, in1_dest, in1_last, in1_ready;
    logic [DATA_W-1:0] in1_data;
    logic              in2_valid, in2_dest, in2_last, in2_ready;
    logic [DATA_W-1:0] in2_data;
    logic              out1_valid, out1_last, out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out2_valid, out2_last, out2_ready;
    logic [DATA_W-1:0] out2_data;
    logic              xbar_ctrl, busy;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks = 0;
    int errors = 0;
    int fires1 = 0;
    int fires2 = 0;

    crossbar_2x2_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in1_valid_i    (in1_valid),
        .in1_dest_i     (in1_dest),
        .in1_last_i     (in1_last),
        .in1_data_i     (in1_data),
        .in1_ready_o    (in1_ready),
        .in2_valid_i    (in2_valid),
        .in2_dest_i     (in2_dest),
        .in2_last_i     (in2_last),
        .in2_data_i     (in2_data),
        .in2_ready_o    (in2_ready),
        .out1_valid_o   (out1_valid),
        .out1_last_o    (out1_last),
        .out1_data_o    (out1_data),
        .out1_ready_i   (out1_ready),
        .out2_valid_o   (out2_valid),
        .out2_last_o    (out2_last),
        .out2_data_o    (out2_data),
        .out2_ready_i   (out2_ready),
        .xbar_ctrl_o    (xbar_ctrl),
        .busy_o         (busy),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-beat counters for the no-loss / no-duplication check.
    always @(posedge clk) begin
        if (in1_valid && in1_ready) fires1 <= fires1 + 1;
        if (in2_valid && in2_ready) fires2 <= fires2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base1;
        int base2;
        bit odd;

        rst = 1'b1;
        in1_valid = 0; in1_dest = 0; in1_last = 0; in1_data = '0;
        in2_valid = 0; in2_dest = 0; in2_last = 0; in2_data = '0;
        out1_ready = 1; out2_ready = 1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_ctrl", xbar_ctrl, 1);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_rdy1", in1_ready, 0);
        check("rst_rdy2", in2_ready, 0);
        check("rst_oval1", out1_valid, 0);
        check("rst_oval2", out2_valid, 0);
        rst = 1'b0;
        tick();

        // ---------------- 1: disjoint dests, 3-beat packets ----------------
        in1_valid = 1; in1_dest = 0; in1_data = 4'h1; in1_last = 0;
        in2_valid = 1; in2_dest = 1; in2_data = 4'h8; in2_last = 0;
        #1;
        check("t1_idle_rdy1", in1_ready, 0);
        check("t1_idle_oval1", out1_valid, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            in1_data = 4'(b + 1);
            in2_data = 4'(b + 8);
            in1_last = (b == 2);
            in2_last = (b == 2);
            #1;
            check("t1_ctrl", xbar_ctrl, 1);
            check("t1_busy", busy, 1);
            check("t1_out1_data", out1_data, b + 1);
            check("t1_out2_data", out2_data, b + 8);
            check("t1_out1_last", out1_last, (b == 2) ? 1 : 0);
            check("t1_rdy1", in1_ready, 1);
            check("t1_rdy2", in2_ready, 1);
            tick();
        end
        in1_valid = 0; in2_valid = 0; in1_last = 0; in2_last = 0;
        #1;
        check("t1_idle_after", busy, 0);
        check("t1_cnt", conflict_cnt, 0);

        // ---------------- 2: conflict on out2, rr starts at in1 ----------------
        in1_valid = 1; in1_dest = 1; in1_data = 4'h3; in1_last = 1;
        in2_valid = 1; in2_dest = 1; in2_data = 4'hC; in2_last = 1;
        tick();
        check("t2a_ctrl", xbar_ctrl, 0);
        check("t2a_rdy1", in1_ready, 1);
        check("t2a_rdy2", in2_ready, 0);
        check("t2a_oval2", out2_valid, 1);
        check("t2a_out2_data", out2_data, 4'h3);
        check("t2a_oval1", out1_valid, 0);
        check("t2a_cnt", conflict_cnt, 1);
        tick();
        check("t2_bubble", busy, 0);
        tick();
        check("t2b_ctrl", xbar_ctrl, 1);
        check("t2b_rdy2", in2_ready, 1);
        check("t2b_rdy1", in1_ready, 0);
        check("t2b_out2_data", out2_data, 4'hC);
        check("t2b_cnt", conflict_cnt, 2);
        in1_valid = 0;
        tick();
        in2_valid = 0;
        #1;
        check("t2_idle", busy, 0);

        // ---------------- 3: backpressure on out1 only ----------------
        base1 = fires1;
        base2 = fires2;
        in1_valid = 1; in1_dest = 0; in1_data = 4'h1; in1_last = 0;
        in2_valid = 1; in2_dest = 1; in2_data = 4'h9; in2_last = 0;
        tick();
        out1_ready = 0;
        #1;
        check("t3_stall_rdy1", in1_ready, 0);
        check("t3_stall_oval1", out1_valid, 1);
        check("t3_stall_data1", out1_data, 4'h1);
        check("t3_flow_rdy2", in2_ready, 1);
        check("t3_flow_data2", out2_data, 4'h9);
        tick();
        in2_data = 4'hA;
        #1;
        check("t3_stall2_rdy1", in1_ready, 0);
        check("t3_stall2_oval1", out1_valid, 1);
        check("t3_stall2_data1", out1_data, 4'h1);
        check("t3_flow2_data2", out2_data, 4'hA);
        tick();
        out1_ready = 1;
        in2_data = 4'hB; in2_last = 1;
        #1;
        check("t3_release_rdy1", in1_ready, 1);
        check("t3_release_data1", out1_data, 4'h1);
        check("t3_last2", out2_last, 1);
        tick();
        in1_data = 4'h2; in1_last = 1;
        in2_valid = 0; in2_last = 0;
        #1;
        check("t3_rdy2_done", in2_ready, 0);
        check("t3_oval2_done", out2_valid, 0);
        check("t3_data1_b2", out1_data, 4'h2);
        check("t3_last1", out1_last, 1);
        check("t3_busy", busy, 1);
        tick();
        in1_valid = 0; in1_last = 0;
        #1;
        check("t3_idle", busy, 0);
        check("t3_beats1", fires1 - base1, 2);
        check("t3_beats2", fires2 - base2, 3);

        // ---------------- 4: in2 alone to out1, single beat ----------------
        in2_valid = 1; in2_dest = 0; in2_data = 4'h6; in2_last = 1;
        tick();
        check("t4_ctrl", xbar_ctrl, 0);
        check("t4_oval1", out1_valid, 1);
        check("t4_data1", out1_data, 4'h6);
        check("t4_last1", out1_last, 1);
        check("t4_oval2", out2_valid, 0);
        check("t4_rdy2", in2_ready, 1);
        tick();
        in2_valid = 0; in2_last = 0;
        #1;
        check("t4_idle", busy, 0);
        check("t4_oval1_idle", out1_valid, 0);

        // ---------------- 5: reset mid-packet ----------------
        in1_valid = 1; in1_dest = 1; in1_data = 4'h4; in1_last = 0;
        tick();
        check("t5_busy", busy, 1);
        check("t5_ctrl", xbar_ctrl, 0);
        check("t5_cnt", conflict_cnt, 2);
        rst = 1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rdy1", in1_ready, 0);
        check("t5_rst_oval1", out1_valid, 0);
        check("t5_rst_oval2", out2_valid, 0);
        check("t5_rst_ctrl", xbar_ctrl, 1);
        check("t5_rst_cnt", conflict_cnt, 0);
        rst = 0;
        in1_valid = 0;
        tick();

        // ---------------- 6: 300 back-to-back conflicts on out1 ----------------
        in1_valid = 1; in1_dest = 0; in1_data = 4'h5; in1_last = 1;
        in2_valid = 1; in2_dest = 0; in2_data = 4'hA; in2_last = 1;
        for (int k = 0; k < 300; k++) begin
            odd = k[0];
            tick();
            check("t6_rdy1", in1_ready, odd ? 0 : 1);
            check("t6_rdy2", in2_ready, odd ? 1 : 0);
            check("t6_ctrl", xbar_ctrl, odd ? 0 : 1);
            check("t6_cnt", conflict_cnt, (k + 1 > 255) ? 255 : k + 1);
            tick();
        end
        in1_valid = 0; in2_valid = 0;
        tick();
        check("t6_final_cnt", conflict_cnt, 255);
        check("t6_final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule : tb_crossbar_2x2_scheduler
`default_nettype wire
